shift_add_mult_ctrl: RTL
========================

// Module: shift_add_mult_ctrl
// PURPOSE
//  Sequencer for the unsigned shift-add multiplier. Owns the A/Q/M registers and the
//  step counter; time-shares the external ripple adder (WIDTH-bit, carry-out) once per step.
//  Accepts one start pulse, runs WIDTH add-shift steps, then returns a 2*WIDTH-bit product.
//  Sits between the host/testbench handshake and the combinational adder datapath.
// PARAMETERS
//  WIDTH   8   operand width; must equal the adder width
//  CNT_W   3   step counter width, = clog2(WIDTH)
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        request; sampled only in IDLE
//  multiplicand  in   WIDTH    operand M, captured on accepted start
//  multiplier    in   WIDTH    operand Q, captured on accepted start
//  busy          out  1        high while in RUN
//  done          out  1        1-cycle pulse, product valid
//  product       out  2*WIDTH  {A,Q}; holds until next accepted start
//  add_a         out  WIDTH    adder operand RA = A register
//  add_b         out  WIDTH    adder operand RB = Q[0] ? M : 0
//  add_sum       in   WIDTH    adder sum
//  add_cout      in   1        adder carry-out
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; A, Q, M, cnt = 0; busy=0, done=0, product=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> load M<=multiplicand, Q<=multiplier, A<=0, cnt<=0; go RUN.
//    RUN: each cycle one step: A<={add_cout, add_sum[WIDTH-1:1]}, Q<={add_sum[0], Q[WIDTH-1:1]},
//         cnt<=cnt+1; after step with cnt==WIDTH-1 go DONE (exactly WIDTH RUN cycles).
//    DONE: done=1 for this single cycle; go IDLE unconditionally.
//  - Latency: start high at edge E0 -> RUN during cycles E0+1..E0+WIDTH -> done high in
//    cycle E0+WIDTH+1 (9 cycles for WIDTH=8). Next start accepted at the earliest in
//    IDLE cycle after DONE (throughput 1 product / WIDTH+2 cycles).
//  - start while RUN or DONE: ignored, no queuing; operand inputs ignored outside IDLE.
//  - Arithmetic: unsigned only; carry from adder is the 9th bit shifted into A[WIDTH-1];
//    no overflow possible, full 2*WIDTH product.
//  - add_a/add_b are driven continuously from registers (no combinational path from
//    start/inputs to adder ports); adder outputs only consumed in RUN.
//  - product = {A,Q}: registered, stable from DONE until the cycle after the next
//    accepted start (values mid-RUN are partial and not to be sampled).
//  - Reset mid-RUN: abort immediately, all registers to reset values, no done pulse.
//  - cnt wraps are never reached: FSM leaves RUN at cnt==WIDTH-1.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//    WIDTH default, CNT_W derivation.
//  - One natural sub-module: mult_shift_reg (A/Q/M registers + step-update logic);
//    FSM and counter stay in this top. The adder remains external, wired at parent level.
//  - No latches; illegal state encoding 2'd3 -> IDLE.
// TESTING
//  1. Reset, start with 0xFF x 0xFF -> busy cycles 1..8, done in cycle 9, product=0xFE01.
//  2. 13 x 11 -> product=0x008F; 0x00 x 0xA5 -> 0x0000; 0x80 x 0x02 -> 0x0100.
//  3. Hold start high through the whole op -> one result per 10 cycles, no extra done,
//     operands changed during RUN do not affect product.
//  4. rst_n low at RUN cycle 4 -> busy=0, done never pulses, product=0; new start works.
//  5. Start in first IDLE cycle after done (back-to-back 0x12 x 0x34, 0xFF x 0x01) ->
//     0x03A8 then 0x00FF, product holds 0x03A8 until second start accepted.
//  6. Self-check add_a/add_b each RUN cycle against reference model; 1000 random pairs.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: default sizes and
// the FSM state encoding.
package shift_add_mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_shift_reg.sv
// A/Q/M register file of the shift-add multiplier plus the per-step update that
// folds the external adder result back into A and Q.
module mult_shift_reg
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;

  // Operand capture on load; one add-and-shift right per step, carry enters A's MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      q_r <= '0;
      m_r <= '0;
    end else if (load) begin
      a_r <= '0;
      q_r <= multiplier;
      m_r <= multiplicand;
    end else if (step) begin
      a_r <= {add_cout, add_sum[WIDTH-1:1]};
      q_r <= {add_sum[0], q_r[WIDTH-1:1]};
      m_r <= m_r;
    end else begin
      a_r <= a_r;
      q_r <= q_r;
      m_r <= m_r;
    end
  end

  assign add_a = a_r;
  assign add_b = q_r[0] ? m_r : '0;
  assign a     = a_r;
  assign q     = q_r;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the unsigned shift-add multiplier: start handshake, step counter
// and IDLE/RUN/DONE control around a time-shared external ripple adder.
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             busy_r;
  logic             done_r;
  logic             load_s;
  logic             step_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] q_s;

  // State, step counter and the status flags, decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Next-state and datapath strobes; the unused encoding falls back to IDLE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          cnt_next_s   = '0;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s     = 1'b1;
        cnt_next_s = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_STEP) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  mult_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_s),
    .step         (step_s),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .a            (a_s),
    .q            (q_s),
    .add_a        (add_a),
    .add_b        (add_b)
  );

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = {a_s, q_s};

endmodule
